// File: rtl/align_ctrl_8_32_pkg.sv
// align_ctrl_8_32_pkg: shared encodings and widths for the 8-to-32 alignment controller.
package align_ctrl_8_32_pkg;
    localparam int BYTE_W = 8;
    localparam int WORD_W = 32;
    localparam int LANES = WORD_W / BYTE_W;
    localparam int IDX_W = $clog2(LANES);
    localparam int CNT_W = 4;
    localparam logic [BYTE_W-1:0] COM_DEFAULT = 8'hBC;
    localparam logic [IDX_W-1:0] LAST_LANE = IDX_W'(LANES - 1);

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        CHECK  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        IDX_HOLD = 2'd0,
        IDX_INC  = 2'd1,
        IDX_CLR  = 2'd2,
        IDX_ONE  = 2'd3
    } idx_op_t;
endpackage

// File: rtl/align_lane_counter.sv
// align_lane_counter: byte position within the current word, wrapping at the last lane.
module align_lane_counter
    import align_ctrl_8_32_pkg::*;
(
    input  logic             clk_4f,
    input  logic             reset,
    input  idx_op_t          op,
    output logic [IDX_W-1:0] idx
);
    always_ff @(posedge clk_4f or posedge reset) begin
        if (reset) idx <= '0;
        else idx <= (op == IDX_INC) ? idx + IDX_W'(1) :
                    (op == IDX_CLR) ? '0 :
                    (op == IDX_ONE) ? IDX_W'(1) : idx;
    end
endmodule

// File: rtl/align_ctrl_8_32.sv
// align_ctrl_8_32: COM-based word alignment and lane steering in front of the 8-to-32 demux.
module align_ctrl_8_32
    import align_ctrl_8_32_pkg::*;
#(
    parameter logic [BYTE_W-1:0] COM = COM_DEFAULT,
    parameter int LOCK_COUNT = 4,
    parameter int LOSS_COUNT = 2
) (
    input  logic              clk_4f,
    input  logic              reset,
    input  logic              valid,
    input  logic [BYTE_W-1:0] data_in,
    output logic [BYTE_W-1:0] byte_out,
    output logic [IDX_W-1:0]  sel,
    output logic              lane_we,
    output logic              word_last,
    output logic              word_drop,
    output logic              lock,
    output logic [1:0]        state
);
    localparam logic [CNT_W-1:0] LOCK_N = CNT_W'(LOCK_COUNT);
    localparam logic [CNT_W-1:0] LOSS_N = CNT_W'(LOSS_COUNT);

    state_t            cs, ns;
    idx_op_t           idx_op;
    logic [IDX_W-1:0]  idx;
    logic [CNT_W-1:0]  com_cnt, com_n, err_cnt, err_n;
    logic [BYTE_W-1:0] byte_n;
    logic [IDX_W-1:0]  sel_n;
    logic              we_n, last_n, drop_n, is_com;

    align_lane_counter u_idx (
        .clk_4f (clk_4f),
        .reset  (reset),
        .op     (idx_op),
        .idx    (idx)
    );

    assign is_com = (data_in == COM);
    assign lock   = (cs == LOCKED);
    assign state  = cs;

    always_comb begin
        ns     = cs;
        idx_op = IDX_HOLD;
        com_n  = com_cnt;
        err_n  = err_cnt;
        byte_n = byte_out;
        sel_n  = sel;
        we_n   = 1'b0;
        last_n = 1'b0;
        drop_n = 1'b0;
        if (valid) begin
            case (cs)
                SEARCH: if (is_com) begin
                    ns     = CHECK;
                    idx_op = IDX_ONE;
                    com_n  = CNT_W'(1);
                end
                CHECK: begin
                    if (is_com) begin
                        // COM off a word boundary restarts the training run from this symbol
                        idx_op = IDX_ONE;
                        com_n  = (idx != '0) ? CNT_W'(1) :
                                 (com_cnt == LOCK_N) ? com_cnt : com_cnt + CNT_W'(1);
                    end else if (idx == '0) begin
                        ns     = SEARCH;
                        com_n  = '0;
                    end else if (idx == LAST_LANE && com_cnt == LOCK_N) begin
                        ns     = LOCKED;
                        idx_op = IDX_CLR;
                        com_n  = '0;
                        err_n  = '0;
                    end else begin
                        idx_op = IDX_INC;
                    end
                end
                LOCKED: begin
                    if (!is_com) begin
                        we_n   = 1'b1;
                        sel_n  = idx;
                        byte_n = data_in;
                        last_n = (idx == LAST_LANE);
                        idx_op = IDX_INC;
                    end else if (idx == '0) begin
                        err_n  = '0;
                    end else begin
                        drop_n = 1'b1;
                        idx_op = IDX_CLR;
                        ns     = (err_cnt + CNT_W'(1) >= LOSS_N) ? SEARCH : LOCKED;
                        err_n  = (err_cnt + CNT_W'(1) >= LOSS_N) ? '0 : err_cnt + CNT_W'(1);
                    end
                end
                default: ns = SEARCH;
            endcase
        end
    end

    always_ff @(posedge clk_4f or posedge reset) begin
        if (reset) begin
            cs        <= SEARCH;
            com_cnt   <= '0;
            err_cnt   <= '0;
            byte_out  <= '0;
            sel       <= '0;
            lane_we   <= 1'b0;
            word_last <= 1'b0;
            word_drop <= 1'b0;
        end else begin
            cs        <= ns;
            com_cnt   <= com_n;
            err_cnt   <= err_n;
            byte_out  <= byte_n;
            sel       <= sel_n;
            lane_we   <= we_n;
            word_last <= last_n;
            word_drop <= drop_n;
        end
    end
endmodule

// File: tb/tb_align_ctrl_8_32.sv
// tb_align_ctrl_8_32: directed and random byte streams checked against a word-level reference model.
module tb_align_ctrl_8_32;
    localparam int LOCK_N = 4;
    localparam int LOSS_N = 2;
    localparam logic [7:0] COM = 8'hBC;

    logic       clk_4f = 1'b0;
    logic       reset = 1'b1;
    logic       valid = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic [7:0] byte_out;
    logic [1:0] sel;
    logic       lane_we, word_last, word_drop, lock;
    logic [1:0] state;

    int tests = 0;
    int fails = 0;

    // Reference model: mode 0/1/2 = search/check/locked, training progress as
    // bytes-since-COM and a count of good words, locked words as a byte queue.
    int         m_mode, m_pos, m_words, m_errs;
    logic [7:0] m_word[$];
    logic       e_we, e_last, e_drop;
    logic [1:0] e_sel;
    logic [7:0] e_byte;

    align_ctrl_8_32 dut (
        .clk_4f    (clk_4f),
        .reset     (reset),
        .valid     (valid),
        .data_in   (data_in),
        .byte_out  (byte_out),
        .sel       (sel),
        .lane_we   (lane_we),
        .word_last (word_last),
        .word_drop (word_drop),
        .lock      (lock),
        .state     (state)
    );

    always #5 clk_4f = ~clk_4f;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_pos = 0; m_words = 0; m_errs = 0;
        m_word.delete();
        e_we = 0; e_last = 0; e_drop = 0;
    endtask

    task automatic model_step(input logic v, input logic [7:0] d);
        e_we = 0; e_last = 0; e_drop = 0;
        if (!v) return;
        if (m_mode == 0) begin
            if (d == COM) begin m_mode = 1; m_pos = 1; m_words = 1; end
        end else if (m_mode == 1) begin
            if (d == COM) begin
                m_words = (m_pos == 0) ? ((m_words < LOCK_N) ? m_words + 1 : LOCK_N) : 1;
                m_pos = 1;
            end else if (m_pos == 0) begin
                m_mode = 0; m_words = 0;
            end else if (m_pos == 3 && m_words == LOCK_N) begin
                m_mode = 2; m_errs = 0; m_words = 0;
                m_word.delete();
            end else begin
                m_pos = (m_pos + 1) % 4;
            end
        end else begin
            if (d != COM) begin
                e_we = 1; e_sel = 2'(m_word.size()); e_byte = d;
                m_word.push_back(d);
                if (m_word.size() == 4) begin e_last = 1; m_word.delete(); end
            end else if (m_word.size() == 0) begin
                m_errs = 0;
            end else begin
                e_drop = 1;
                m_word.delete();
                m_errs++;
                if (m_errs >= LOSS_N) begin m_mode = 0; m_errs = 0; end
            end
        end
    endtask

    task automatic check_all();
        chk("state", 8'(state), 8'(m_mode));
        chk("lock", 8'(lock), 8'(m_mode == 2));
        chk("lane_we", 8'(lane_we), 8'(e_we));
        chk("word_last", 8'(word_last), 8'(e_last));
        chk("word_drop", 8'(word_drop), 8'(e_drop));
        if (e_we) begin
            chk("sel", 8'(sel), 8'(e_sel));
            chk("byte_out", byte_out, e_byte);
        end
    endtask

    task automatic step(input logic v, input logic [7:0] d);
        @(negedge clk_4f);
        valid = v;
        data_in = d;
        @(posedge clk_4f);
        #1;
        model_step(v, d);
        check_all();
    endtask

    task automatic send(input logic [7:0] d);
        step(1'b1, d);
    endtask

    task automatic train(input int n);
        for (int i = 0; i < n; i++) begin
            send(COM); send(8'h00); send(8'h00); send(8'h00);
        end
    endtask

    task automatic async_reset();
        @(negedge clk_4f);
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        chk("rst_state", 8'(state), 8'd0);
        chk("rst_lock", 8'(lock), 8'd0);
        chk("rst_we", 8'(lane_we), 8'd0);
        chk("rst_last", 8'(word_last), 8'd0);
        chk("rst_drop", 8'(word_drop), 8'd0);
        chk("rst_sel", 8'(sel), 8'd0);
        chk("rst_byte", byte_out, 8'd0);
        @(negedge clk_4f);
        reset = 1'b0;
    endtask

    function automatic logic [7:0] filler();
        logic [7:0] d;
        d = 8'($urandom_range(0, 255));
        return (d == COM) ? 8'h3C : d;
    endfunction

    initial begin
        model_reset();
        #2;
        chk("init_state", 8'(state), 8'd0);
        chk("init_byte", byte_out, 8'd0);
        chk("init_we", 8'(lane_we), 8'd0);
        @(negedge clk_4f);
        reset = 1'b0;
        step(1'b0, 8'h00);

        train(LOCK_N);
        chk("lock_after_16", 8'(lock), 8'd1);
        send(8'hEE); send(8'hFF); send(8'hFD); send(8'hCC);
        chk("last_on_cc", 8'(word_last), 8'd1);

        send(8'hAA); send(8'h12); send(8'hBB); send(8'h01);
        send(COM);
        for (int i = 0; i < 3; i++) step(1'b0, 8'h77);
        send(8'h55);
        chk("gap_sel0", 8'(sel), 8'd0);
        send(8'h56); send(8'h57); send(8'h58);

        send(8'hAA); send(8'h12); send(COM);
        chk("drop1_lock", 8'(lock), 8'd1);
        send(8'hEE); send(COM);
        chk("drop2_lock", 8'(lock), 8'd0);
        chk("drop2_pulse", 8'(word_drop), 8'd1);

        send(COM); send(8'h00); send(8'h00); send(8'h00); send(8'h11);
        chk("bad_train", 8'(state), 8'd0);

        send(COM); send(8'h00); send(COM); send(8'h00); send(8'h00); send(8'h00);
        train(LOCK_N - 1);
        chk("realign_lock", 8'(lock), 8'd1);

        send(8'h21); send(8'h22);
        async_reset();
        step(1'b0, 8'h00);
        chk("post_rst_search", 8'(state), 8'd0);

        for (int it = 0; it < 600; it++) begin
            int kind;
            kind = $urandom_range(0, 9);
            if (kind < 4) begin
                send(COM);
                for (int k = 0; k < 3; k++) step($urandom_range(0, 9) != 0, filler());
            end else if (kind < 8) begin
                for (int k = 0; k < 4; k++) step($urandom_range(0, 7) != 0, filler());
            end else begin
                step($urandom_range(0, 3) != 0, ($urandom_range(0, 2) == 0) ? COM : filler());
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/align_ctrl_8_32.md
Name: align_ctrl_8_32

Overview:
- Alignment and sequencing controller placed in front of the 8-to-32 byte demux in the PCIe physical-layer receive path.
- Monitors the incoming byte stream for the COM symbol and declares lock after a run of correctly spaced training words.
- Once locked, steers each data byte into lane 0..3 of the demux, flags word completion, and drops lock after repeated misalignment.

Parameters:
- COM, 8'hBC, alignment/keepalive symbol.
- LOCK_COUNT, 4, consecutive well-spaced training words required for lock (range 1..15).
- LOSS_COUNT, 2, misalignment errors while locked before lock is dropped (range 1..15).

Ports:
- clk_4f  input  1  byte clock.
- reset  input  1  asynchronous, active-high; clears all state.
- valid  input  1  data_in qualifier.
- data_in  input  8  received byte.
- byte_out  output  8  registered copy of the byte being written to the demux.
- sel  output  2  demux lane for byte_out (0 = bits 7:0 of the word first).
- lane_we  output  1  write enable for the demux lane.
- word_last  output  1  high with lane_we on the 4th byte of a word.
- word_drop  output  1  one-cycle pulse when a partial word is discarded.
- lock  output  1  high in LOCKED.
- state  output  2  0 SEARCH, 1 CHECK, 2 LOCKED (debug).

Behaviour:
- Single clock clk_4f. Reset is asynchronous and active-high.
- On reset, all outputs are 0 and state = SEARCH. Internal idx, com_cnt and err_cnt are 0.
- Latency: all outputs are registered. A byte sampled at edge N appears on byte_out/sel/lane_we after edge N.
- valid = 0 in any state: idle cycle. No counters change, lane_we = 0, word_last = 0, word_drop = 0.
- SEARCH:
  - valid && data_in == COM -> CHECK, idx = 1, com_cnt = 1.
  - Any other byte is ignored.
- CHECK: training words are COM followed by 3 filler bytes of any non-COM value. idx counts 0..3 and wraps.
  - Non-COM at idx 1..3 -> idx++.
  - COM at idx 0 -> com_cnt++, idx = 1.
  - Non-COM at idx 0 -> SEARCH.
  - COM at idx 1..3 -> realign: idx = 1, com_cnt = 1.
  - Non-COM at idx 3 with com_cnt == LOCK_COUNT -> LOCKED, idx = 0, err_cnt = 0.
  - lane_we is never asserted in CHECK.
- LOCKED:
  - Non-COM valid byte -> lane_we = 1, sel = idx, byte_out = data_in, idx++ (wraps 3 -> 0). word_last = 1 when idx was 3.
  - COM at idx 0 (keepalive) -> no write, idx unchanged, err_cnt = 0.
  - COM at idx 1..3 (misalignment) -> no write, word_drop = 1, idx = 0, err_cnt++.
  - If err_cnt reaches LOSS_COUNT -> SEARCH, lock falls on the same edge, err_cnt = 0.
- Simultaneous lock loss and word_drop: both take effect on the same edge.
- Reset asserted mid-word discards the partial word with no word_drop pulse.
- com_cnt saturates at LOCK_COUNT. err_cnt saturates at LOSS_COUNT.

Decomposition:
- Shared package: state encodings (SEARCH, CHECK, LOCKED), the COM default, and the width constants (BYTE_W = 8, WORD_W = 32, LANES = 4).
- Natural sub-module: align_lane_counter, holding the 2-bit idx with wrap, hold and clear.
- FSM, com_cnt and err_cnt stay in the top module.

Test Plan:
- Reset: assert reset between bytes mid-word in LOCKED -> all outputs 0 immediately (asynchronous), state = 0; after release, 1 cycle of idle -> still SEARCH.
- Lock acquire: 4× {BC,00,00,00}, then EE,FF,FD,CC -> lock rises after the 16th byte; lane_we on 4 cycles with sel 0,1,2,3, byte_out EE,FF,FD,CC; word_last only with CC.
- Bad training: BC,00,00,00,11 -> state returns to SEARCH after the 11 byte; lock stays 0; lane_we never asserted.
- Keepalive and gaps while locked: AA,12,BB,01, BC, valid=0 for 3 cycles, 55 -> BC produces no write; idle cycles hold idx; 55 written with sel = 0.
- Misalignment with LOSS_COUNT = 2: AA,12,BC -> word_drop pulse, lock stays 1; EE,BC -> second word_drop, lock falls on the same edge, state = SEARCH.
- Realign in CHECK: BC,00,BC,00,00,00 then 3 more training words -> lock asserted, counting from the second BC.
